// File: rtl/frame_receiver.sv
// Byte-stream frame parser and sample playout buffer feeding the FM transmitter.
// Optional XOR checksum byte is enabled by defining FRAME_RECEIVER_CSUM_EN.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_HUNT    | waiting for the first ID character
// S_ID1     | first ID character seen, expecting the second
// S_ID2     | second ID character seen, expecting the third
// S_LEN     | expecting the sample count L
// S_PAYLOAD | assembling L samples of WIDTH/8 bytes each
// S_CSUM    | expecting the XOR checksum byte
// S_PLAY    | releasing one buffered sample per stb_req
module frame_receiver #(
    parameter logic [23:0] ID     = "NTN",
    parameter int          WIDTH  = 16,
    parameter int          LENGTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       byte_in,
    input  logic             byte_stb,
    input  logic             stb_req,
    output logic [WIDTH-1:0] data_out,
    output logic             stb_out,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int BPS   = WIDTH / 8;
    localparam int IDX_W = $clog2(LENGTH + 1);
    localparam int BC_W  = (BPS > 1) ? $clog2(BPS) : 1;

    localparam logic [7:0]      LEN_MAX = 8'(LENGTH);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ID1,
        S_ID2,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_PLAY
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [7:0]        len_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [BC_W-1:0]   byte_cnt;
    logic [WIDTH-1:0]  shift_q;
    logic [WIDTH-1:0]  sample_asm;
    logic [WIDTH-1:0]  sample_buf [LENGTH];
`ifdef FRAME_RECEIVER_CSUM_EN
    logic [7:0]        csum_q;
`endif

    logic              ok_nxt;
    logic              err_nxt;
    logic              ovr_nxt;
    logic              len_load;
    logic              sample_wr;
    logic              play_adv;
    logic              wr_last;
    logic              rd_last;
    logic              byte_last;

    // Incoming byte lands in the LSBs; older bytes shift toward the MSB.
    assign sample_asm = WIDTH'({shift_q, byte_in});

    assign wr_last   = ((8'(wr_idx) + 8'd1) == len_q);
    assign rd_last   = ((8'(rd_idx) + 8'd1) == len_q);
    assign byte_last = (byte_cnt == BC_LAST);

    assign busy = (state == S_PLAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        ovr_nxt   = 1'b0;
        len_load  = 1'b0;
        sample_wr = 1'b0;
        play_adv  = 1'b0;
        case (state)
            S_HUNT: begin
                if (byte_stb && byte_in == ID[23:16]) begin
                    state_nxt = S_ID1;
                end
            end
            S_ID1: begin
                if (byte_stb) begin
                    if (byte_in == ID[15:8]) begin
                        state_nxt = S_ID2;
                    end else if (byte_in == ID[23:16]) begin
                        state_nxt = S_ID1;
                    end else begin
                        state_nxt = S_HUNT;
                    end
                end
            end
            S_ID2: begin
                if (byte_stb) begin
                    if (byte_in == ID[7:0]) begin
                        state_nxt = S_LEN;
                    end else if (byte_in == ID[23:16]) begin
                        state_nxt = S_ID1;
                    end else begin
                        state_nxt = S_HUNT;
                    end
                end
            end
            S_LEN: begin
                if (byte_stb) begin
                    if (byte_in == 8'd0 || byte_in > LEN_MAX) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HUNT;
                    end else begin
                        len_load  = 1'b1;
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (byte_stb && byte_last) begin
                    sample_wr = 1'b1;
                    if (wr_last) begin
`ifdef FRAME_RECEIVER_CSUM_EN
                        state_nxt = S_CSUM;
`else
                        ok_nxt    = 1'b1;
                        state_nxt = S_PLAY;
`endif
                    end
                end
            end
`ifdef FRAME_RECEIVER_CSUM_EN
            S_CSUM: begin
                if (byte_stb) begin
                    if (byte_in == csum_q) begin
                        ok_nxt    = 1'b1;
                        state_nxt = S_PLAY;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HUNT;
                    end
                end
            end
`endif
            S_PLAY: begin
                // The host is expected to pace itself; anything arriving now is lost.
                ovr_nxt = byte_stb;
                if (stb_req) begin
                    play_adv = 1'b1;
                    if (rd_last) begin
                        state_nxt = S_HUNT;
                    end
                end
            end
            default: begin
                state_nxt = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            stb_out   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            len_q     <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            byte_cnt  <= '0;
            shift_q   <= '0;
`ifdef FRAME_RECEIVER_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            stb_out   <= stb_req;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            overrun   <= ovr_nxt;
            // Requests outside playout are answered with silence so the stream never stalls.
            if (stb_req) begin
                data_out <= play_adv ? sample_buf[rd_idx] : '0;
            end
            if (len_load) begin
                len_q    <= byte_in;
                wr_idx   <= '0;
                rd_idx   <= '0;
                byte_cnt <= '0;
`ifdef FRAME_RECEIVER_CSUM_EN
                csum_q   <= '0;
`endif
            end
            if (state == S_PAYLOAD && byte_stb) begin
                shift_q  <= sample_asm;
                byte_cnt <= byte_last ? '0 : byte_cnt + 1'b1;
`ifdef FRAME_RECEIVER_CSUM_EN
                csum_q   <= csum_q ^ byte_in;
`endif
                if (sample_wr) begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (play_adv) begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    // Sample storage needs no reset: playout only reads entries written by the current frame.
    always_ff @(posedge clk) begin
        if (sample_wr) begin
            sample_buf[wr_idx] <= sample_asm;
        end
    end

endmodule

// File: tb/tb_frame_receiver.sv
// Directed plus randomized bench for frame_receiver; expectations come from
// sample queues and frame rules, with the checksum path following FRAME_RECEIVER_CSUM_EN.
module tb_frame_receiver;

    localparam logic [23:0] ID = "NTN";
`ifdef FRAME_RECEIVER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        byte_stb;
    logic        stb_req;
    logic [15:0] data_out;
    logic        stb_out;
    logic        frame_ok;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  fb[$];
    logic [15:0] fs[$];

    always #5 clk = ~clk;

    frame_receiver #(.ID(ID), .WIDTH(16), .LENGTH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (byte_in),
        .byte_stb  (byte_stb),
        .stb_req   (stb_req),
        .data_out  (data_out),
        .stb_out   (stb_out),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic bs, input logic [7:0] b, input logic rq);
        byte_stb = bs;
        byte_in  = b;
        stb_req  = rq;
        @(posedge clk);
        #1;
        byte_stb = 1'b0;
        byte_in  = 8'h00;
        stb_req  = 1'b0;
    endtask

    // Frame bytes from the sample queue fs: ID, L, MSB-first samples, optional XOR byte.
    function automatic void build(input bit corrupt);
        logic [7:0] x;
        logic [7:0] csum_byte;
        fb.delete();
        fb.push_back(ID[23:16]);
        fb.push_back(ID[15:8]);
        fb.push_back(ID[7:0]);
        fb.push_back(8'(fs.size()));
        x = 8'h00;
        foreach (fs[i]) begin
            fb.push_back(fs[i][15:8]);
            fb.push_back(fs[i][7:0]);
            x = x ^ fs[i][15:8] ^ fs[i][7:0];
        end
        csum_byte = corrupt ? ~x : x;
`ifdef FRAME_RECEIVER_CSUM_EN
        fb.push_back(csum_byte);
`endif
    endfunction

    function automatic void header_only(input logic [7:0] l);
        fb.delete();
        fb.push_back(ID[23:16]);
        fb.push_back(ID[15:8]);
        fb.push_back(ID[7:0]);
        fb.push_back(l);
    endfunction

    // The last byte of fb always terminates the frame (accept or reject).
    task automatic send_frame(input bit exp_ok, input bit req_last);
        for (int i = 0; i < fb.size(); i++) begin
            bit last;
            last = (i == fb.size() - 1);
            cyc(1'b1, fb[i], last && req_last);
            chk("frame_ok", frame_ok, last && exp_ok);
            chk("frame_err", frame_err, last && !exp_ok);
            chk("busy_rx", busy, last && exp_ok);
            chk("stb_rx", stb_out, last && req_last);
            if (last && req_last) chk("silence_on_accept", data_out, 16'h0000);
        end
    endtask

    // Requests k = first .. first+n-1; samples come from fs when the frame was accepted.
    task automatic play(input int first, input int n, input bit accepted);
        logic [15:0] exp;
        exp = 16'h0000;
        for (int k = first; k < first + n; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            exp = (accepted && k < fs.size()) ? fs[k] : 16'h0000;
            chk("stb_out", stb_out, 1'b1);
            chk("data_out", data_out, exp);
            chk("busy_play", busy, accepted && (k < int'(fs.size()) - 1));
            chk("overrun_idle", overrun, 1'b0);
        end
        cyc(1'b0, 8'h00, 1'b0);
        chk("stb_idle", stb_out, 1'b0);
        chk("data_hold", data_out, exp);
    endtask

    initial begin
        rst_n    = 1'b0;
        byte_in  = 8'h00;
        byte_stb = 1'b0;
        stb_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data_out, 16'h0000);
        chk("rst_stb", stb_out, 1'b0);
        chk("rst_ok", frame_ok, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Silence while hunting
        play(0, 2, 1'b0);

        // Basic frame, stb_req coincident with the accepting byte
        fs = '{16'h278E, 16'hD872};
        build(1'b0);
        send_frame(1'b1, 1'b1);
        play(0, 3, 1'b1);

        // Corrupt checksum (only meaningful with the checksum byte present)
        if (CSUM_ON) begin
            build(1'b1);
            send_frame(1'b0, 1'b0);
            play(0, 1, 1'b0);
        end

        // Resync after a false start
        fs = '{16'h7FFF};
        build(1'b0);
        fb.push_front(8'h4E);
        send_frame(1'b1, 1'b0);
        play(0, 1, 1'b1);

        // Length bounds, then a valid frame
        header_only(8'd0);
        send_frame(1'b0, 1'b0);
        header_only(8'd13);
        send_frame(1'b0, 1'b0);
        fs = '{16'h0102, 16'h8000, 16'hFFFF};
        build(1'b0);
        send_frame(1'b1, 1'b0);
        play(0, 3, 1'b1);

        // Maximum length frame
        fs.delete();
        for (int i = 0; i < 12; i++) fs.push_back(16'($urandom));
        build(1'b0);
        send_frame(1'b1, 1'b0);
        play(0, 13, 1'b1);

        // Overrun with 2 samples left
        fs = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        build(1'b0);
        send_frame(1'b1, 1'b0);
        play(0, 2, 1'b1);
        cyc(1'b1, 8'h4E, 1'b0);
        chk("overrun", overrun, 1'b1);
        chk("busy_ovr", busy, 1'b1);
        chk("stb_ovr", stb_out, 1'b0);
        play(2, 2, 1'b1);

        // Async reset after 5 payload bytes
        chk("pre_rst_data", data_out, 16'h4444);
        fs = '{16'hAAAA, 16'h5555, 16'hC3C3, 16'h3C3C};
        build(1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, fb[i], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", data_out, 16'h0000);
        chk("arst_stb", stb_out, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ok", frame_ok, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fs = '{16'h0F0F, 16'hF00D};
        build(1'b0);
        send_frame(1'b1, 1'b0);
        play(0, 2, 1'b1);

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                header_only(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(13, 255)));
                send_frame(1'b0, 1'($urandom_range(0, 1)));
                play(0, 1, 1'b0);
            end else begin
                bit corrupt;
                bit ok;
                fs.delete();
                for (int i = 0; i < $urandom_range(1, 12); i++) fs.push_back(16'($urandom));
                corrupt = (kind == 1);
                ok = !(corrupt && CSUM_ON);
                build(corrupt);
                send_frame(ok, 1'($urandom_range(0, 1)));
                play(0, ok ? fs.size() + $urandom_range(0, 2) : 1, ok);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
